gf180mcu_fd_sc_mcu7t5v0__dlysync: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__DLYSYNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__dlysync

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__dlysync.sv | 91 +++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlysync.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dlysync.sv
`default_nettype none
// =============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__dlysync
// Brief    : Tapped delay line with run-time tap select and a fill-valid flag.
//            Define GF180MCU_FD_SC_MCU7T5V0__DLYSYNC_BYPASS_EN for a zero-latency tap 0.
// Revision : 1.0 - initial release
// =============================================================================
module gf180mcu_fd_sc_mcu7t5v0__dlysync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RN,
    input  logic                     EN,
    input  logic                     LD,
    input  logic [$clog2(DEPTH)-1:0] SEL,
    input  logic [WIDTH-1:0]         I,
    output logic [WIDTH-1:0]         Z,
    output logic                     VLD
);

    localparam int SW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [SW-1:0] C_MAX_TAP = SW'(DEPTH - 1);
    localparam logic [CW-1:0] C_FULL    = CW'(DEPTH);

    logic [WIDTH-1:0] r_stage [DEPTH];
    logic [SW-1:0]    r_tap;
    logic [CW-1:0]    r_cnt;
    logic [SW-1:0]    w_sel_clamped;
    logic [WIDTH-1:0] w_z;
    logic             w_vld;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else if (EN) begin
            r_stage[0] <= I;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    always_comb begin
        w_sel_clamped = SEL;
        if (SEL > C_MAX_TAP) begin
            w_sel_clamped = C_MAX_TAP;
        end
    end

    // A load restarts the fill count even when it coincides with a shift.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_tap <= '0;
            r_cnt <= '0;
        end else if (LD) begin
            r_tap <= w_sel_clamped;
            r_cnt <= '0;
        end else if (EN && (r_cnt != C_FULL)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

`ifdef GF180MCU_FD_SC_MCU7T5V0__DLYSYNC_BYPASS_EN
    // Tap 0 is a wire from I; taps n>=1 read stage n-1.
    always_comb begin
        w_z   = '0;
        w_vld = 1'b0;
        if (r_tap == '0) begin
            w_z   = RN ? I : '0;
            w_vld = RN;
        end else begin
            w_z   = r_stage[r_tap - SW'(1)];
            w_vld = (r_cnt >= CW'(r_tap));
        end
    end
`else
    always_comb begin
        w_z   = r_stage[r_tap];
        w_vld = (r_cnt >= (CW'(r_tap) + CW'(1)));
    end
`endif

    assign Z   = w_z;
    assign VLD = w_vld;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dlysync.sv
`default_nettype none
// Testbench for gf180mcu_fd_sc_mcu7t5v0__dlysync: directed scenarios on a
// DEPTH=8 and a DEPTH=6 instance sharing the same stimulus.
module tb_gf180mcu_fd_sc_mcu7t5v0__dlysync;

    logic       CLK;
    logic       RN;
    logic       EN;
    logic       LD;
    logic [2:0] SEL;
    logic [0:0] I;
    logic [0:0] Z8;
    logic       VLD8;
    logic [0:0] Z6;
    logic       VLD6;

    int checks   = 0;
    int failures = 0;

    gf180mcu_fd_sc_mcu7t5v0__dlysync #(.WIDTH(1), .DEPTH(8)) dut8 (
        .CLK(CLK), .RN(RN), .EN(EN), .LD(LD), .SEL(SEL), .I(I), .Z(Z8), .VLD(VLD8)
    );

    gf180mcu_fd_sc_mcu7t5v0__dlysync #(.WIDTH(1), .DEPTH(6)) dut6 (
        .CLK(CLK), .RN(RN), .EN(EN), .LD(LD), .SEL(SEL), .I(I), .Z(Z6), .VLD(VLD6)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush();
        LD = 1'b0;
        EN = 1'b1;
        I  = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        RN = 1'b0; EN = 1'b1; LD = 1'b0; SEL = 3'd0; I = 1'b1;
        repeat (3) tick();
        checks++;
        if ({Z8, VLD8, Z6, VLD6} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold: got z8=%b v8=%b z6=%b v6=%b want all 0", Z8, VLD8, Z6, VLD6);
        end
        RN = 1'b1;
        tick();
        checks++;
        if ({Z8, VLD8, Z6, VLD6} !== 4'b1111) begin
            failures++;
            $display("FAIL reset_release: got z8=%b v8=%b z6=%b v6=%b want all 1", Z8, VLD8, Z6, VLD6);
        end
    endtask

    task automatic test_latency();
        flush();
        for (int k = 1; k <= 8; k++) begin
            LD  = (k == 1);
            SEL = 3'd5;
            I   = (k == 1);
            EN  = 1'b1;
            tick();
            checks++;
            if (Z8 !== 1'(k == 6) || VLD8 !== (k >= 7)) begin
                failures++;
                $display("FAIL latency edge %0d: got z=%b vld=%b want z=%b vld=%b",
                         k, Z8, VLD8, (k == 6), (k >= 7));
            end
        end
    endtask

    task automatic test_stall();
        flush();
        for (int k = 1; k <= 10; k++) begin
            LD  = (k == 1);
            SEL = 3'd3;
            I   = (k == 1);
            EN  = (k % 2 == 1);
            tick();
            checks++;
            if (Z8 !== 1'(k == 7 || k == 8) || VLD8 !== (k >= 9)) begin
                failures++;
                $display("FAIL stall edge %0d: got z=%b vld=%b want z=%b vld=%b",
                         k, Z8, VLD8, (k == 7 || k == 8), (k >= 9));
            end
        end
    endtask

    task automatic test_retarget();
        flush();
        for (int k = 1; k <= 8; k++) begin
            LD  = (k == 1 || k == 5);
            SEL = (k < 5) ? 3'd7 : 3'd2;
            I   = (k == 3);
            EN  = 1'b1;
            tick();
            checks++;
            if (Z8 !== 1'(k == 5) || VLD8 !== (k == 8)) begin
                failures++;
                $display("FAIL retarget edge %0d: got z=%b vld=%b want z=%b vld=%b",
                         k, Z8, VLD8, (k == 5), (k == 8));
            end
        end
    endtask

    task automatic test_back_to_back();
        flush();
        for (int k = 1; k <= 4; k++) begin
            LD  = (k <= 2);
            SEL = (k == 1) ? 3'd6 : 3'd1;
            I   = (k == 1);
            EN  = 1'b1;
            tick();
            checks++;
            if (Z8 !== 1'(k == 2) || VLD8 !== (k == 4)) begin
                failures++;
                $display("FAIL back_to_back edge %0d: got z=%b vld=%b want z=%b vld=%b",
                         k, Z8, VLD8, (k == 2), (k == 4));
            end
        end
    endtask

    task automatic test_clamp_async_reset();
        flush();
        for (int k = 1; k <= 7; k++) begin
            LD  = (k == 1);
            SEL = 3'd7;
            I   = 1'b1;
            EN  = 1'b1;
            tick();
            checks++;
            if (Z6 !== 1'(k >= 6) || VLD6 !== (k >= 7) || Z8 !== 1'b0) begin
                failures++;
                $display("FAIL clamp edge %0d: got z6=%b v6=%b z8=%b want z6=%b v6=%b z8=0",
                         k, Z6, VLD6, Z8, (k >= 6), (k >= 7));
            end
        end
        #1 RN = 1'b0;
        #1;
        checks++;
        if ({Z8, VLD8, Z6, VLD6} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset: got z8=%b v8=%b z6=%b v6=%b want all 0", Z8, VLD8, Z6, VLD6);
        end
        #1 RN = 1'b1;
        LD = 1'b0; EN = 1'b1; I = 1'b1;
        tick();
        checks++;
        if (Z6 !== 1'b1 || VLD6 !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_fill: got z6=%b v6=%b want z6=1 v6=1", Z6, VLD6);
        end
    endtask

    task automatic test_bypass();
        LD = 1'b0; EN = 1'b0; I = 1'b0;
        #1;
        checks++;
        if (Z8 !== 1'b0 || VLD8 !== 1'b1) begin
            failures++;
            $display("FAIL bypass_low: got z=%b vld=%b want z=0 vld=1", Z8, VLD8);
        end
        I = 1'b1;
        #1;
        checks++;
        if (Z8 !== 1'b1 || VLD8 !== 1'b1) begin
            failures++;
            $display("FAIL bypass_high: got z=%b vld=%b want z=1 vld=1", Z8, VLD8);
        end
        LD = 1'b1; SEL = 3'd1; EN = 1'b1; I = 1'b1;
        tick();
        checks++;
        if (Z8 !== 1'b1 || VLD8 !== 1'b0) begin
            failures++;
            $display("FAIL bypass_tap1_load: got z=%b vld=%b want z=1 vld=0", Z8, VLD8);
        end
        LD = 1'b0; I = 1'b0;
        tick();
        checks++;
        if (Z8 !== 1'b0 || VLD8 !== 1'b1) begin
            failures++;
            $display("FAIL bypass_tap1_next: got z=%b vld=%b want z=0 vld=1", Z8, VLD8);
        end
    endtask

    initial begin
        RN = 1'b0; EN = 1'b0; LD = 1'b0; SEL = 3'd0; I = 1'b0;
        test_reset();
`ifdef GF180MCU_FD_SC_MCU7T5V0__DLYSYNC_BYPASS_EN
        test_bypass();
`else
        test_latency();
        test_stall();
        test_retarget();
        test_back_to_back();
        test_clamp_async_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
